// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: next-PC select encodings, base opcodes,
// fetch FSM states and the default reset PC.
package riscv_pkg;

   localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
   localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2,
      ST_HALT  = 2'd3
   } fetch_state_t;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection with word-alignment check.
// Kept standalone so the pipelined core can reuse it unchanged.
module pc_next_sel
   import riscv_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [1:0]  pc_src,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic [31:0] jump_target,
   output logic [31:0] pc_plus4,
   output logic [31:0] next_pc,
   output logic        misaligned
);

   assign pc_plus4 = pc + 32'd4;

   always_comb begin
      next_pc = pc_plus4;
      case (pc_src)
         PC_SRC_BRANCH: next_pc = branch_taken ? branch_target : pc_plus4;
         PC_SRC_JUMP:   next_pc = jump_target;
         default:       next_pc = pc_plus4;
      endcase
   end

   assign misaligned = (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch: owns the PC, fetches over a req/valid handshake
// and holds the instruction for the control unit until it commits.
module fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_valid,
   input  logic [31:0] imem_rdata,
   input  logic [1:0]  pc_src,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic [31:0] jump_target,
   input  logic        advance,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [6:0]  opcode,
   output logic [2:0]  funct3,
   output logic [6:0]  funct7,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        misaligned_err
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  inst_q, inst_d;
   logic         inst_valid_q, inst_valid_d;
   logic         imem_req_q, imem_req_d;
   logic         misaligned_err_q, misaligned_err_d;
   logic [31:0]  next_pc;
   logic         next_misaligned;

   pc_next_sel u_pc_next_sel (
      .pc            (pc_q),
      .pc_src        (pc_src),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump_target   (jump_target),
      .pc_plus4      (pc_plus4),
      .next_pc       (next_pc),
      .misaligned    (next_misaligned)
   );

   always_comb begin
      state_d          = state_q;
      pc_d             = pc_q;
      inst_d           = inst_q;
      inst_valid_d     = inst_valid_q;
      imem_req_d       = imem_req_q;
      misaligned_err_d = misaligned_err_q;
      case (state_q)
         ST_IDLE: begin
            state_d    = ST_FETCH;
            imem_req_d = 1'b1;
         end
         ST_FETCH: begin
            // advance is deliberately not looked at here
            if (imem_valid) begin
               inst_d       = imem_rdata;
               inst_valid_d = 1'b1;
               imem_req_d   = 1'b0;
               state_d      = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (advance) begin
               if (!next_misaligned) begin
                  pc_d         = next_pc;
                  inst_valid_d = 1'b0;
                  imem_req_d   = 1'b1;
                  state_d      = ST_FETCH;
               end else begin
                  misaligned_err_d = 1'b1;
                  state_d          = ST_HALT;
               end
            end
         end
         ST_HALT: begin
            // faulting instruction stays visible until reset
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= ST_IDLE;
         pc_q             <= RESET_PC;
         inst_q           <= 32'd0;
         inst_valid_q     <= 1'b0;
         imem_req_q       <= 1'b0;
         misaligned_err_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         pc_q             <= pc_d;
         inst_q           <= inst_d;
         inst_valid_q     <= inst_valid_d;
         imem_req_q       <= imem_req_d;
         misaligned_err_q <= misaligned_err_d;
      end
   end

   assign imem_req       = imem_req_q;
   assign imem_addr      = pc_q;
   assign pc             = pc_q;
   assign inst           = inst_q;
   assign inst_valid     = inst_valid_q;
   assign misaligned_err = misaligned_err_q;
   assign opcode         = inst_q[6:0];
   assign funct3         = inst_q[14:12];
   assign funct7         = inst_q[31:25];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with instruction/address scoreboards.
module tb_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_valid;
   logic [31:0] imem_rdata;
   logic [1:0]  pc_src;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] jump_target;
   logic        advance;
   logic        inst_valid;
   logic [31:0] inst;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        misaligned_err;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_inst_q[$];
   logic [31:0] exp_addr_q[$];

   fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_valid     (imem_valid),
      .imem_rdata     (imem_rdata),
      .pc_src         (pc_src),
      .branch_taken   (branch_taken),
      .branch_target  (branch_target),
      .jump_target    (jump_target),
      .advance        (advance),
      .inst_valid     (inst_valid),
      .inst           (inst),
      .opcode         (opcode),
      .funct3         (funct3),
      .funct7         (funct7),
      .pc             (pc),
      .pc_plus4       (pc_plus4),
      .misaligned_err (misaligned_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pop_inst(output logic [31:0] v);
      if (exp_inst_q.size() == 0) begin
         v = 32'hDEAD_BEEF;
         errors++;
         $error("FAIL inst_scoreboard_empty");
      end else v = exp_inst_q.pop_front();
   endtask

   task automatic pop_addr(output logic [31:0] v);
      if (exp_addr_q.size() == 0) begin
         v = 32'hDEAD_BEEF;
         errors++;
         $error("FAIL addr_scoreboard_empty");
      end else v = exp_addr_q.pop_front();
   endtask

   // Called at a negedge with a request outstanding; returns after the
   // response has been sampled, at the following negedge.
   task automatic respond(input logic [31:0] data, input int waits);
      logic [31:0] e;
      for (int i = 0; i < waits; i++) begin
         imem_valid = 1'b0;
         imem_rdata = $urandom;
         @(negedge clk);
         chk("req_held_wait", {31'd0, imem_req}, 32'd1);
         chk("inst_valid_low_wait", {31'd0, inst_valid}, 32'd0);
      end
      imem_valid = 1'b1;
      imem_rdata = data;
      exp_inst_q.push_back(data);
      @(negedge clk);
      imem_valid = 1'b0;
      imem_rdata = $urandom;
      pop_inst(e);
      chk("inst", inst, e);
      chk("inst_valid_high", {31'd0, inst_valid}, 32'd1);
      chk("req_low_hold", {31'd0, imem_req}, 32'd0);
      $display("fetch addr=%h inst=%h waits=%0d", pc, inst, waits);
   endtask

   // Request must reappear exactly one cycle after advance is sampled.
   task automatic do_advance(input logic [1:0] src, input logic taken,
                             input logic [31:0] bt, input logic [31:0] jt,
                             input logic [31:0] exp_addr);
      logic [31:0] e;
      exp_addr_q.push_back(exp_addr);
      pc_src = src; branch_taken = taken; branch_target = bt; jump_target = jt;
      advance = 1'b1;
      @(negedge clk);
      advance = 1'b0;
      pop_addr(e);
      chk("next_req", {31'd0, imem_req}, 32'd1);
      chk("next_addr", imem_addr, e);
      chk("next_pc", pc, e);
      chk("inst_valid_cleared", {31'd0, inst_valid}, 32'd0);
      chk("no_err", {31'd0, misaligned_err}, 32'd0);
      $display("advance src=%b taken=%b -> addr=%h", src, taken, imem_addr);
   endtask

   initial begin
      rst_n = 1'b0; imem_valid = 1'b0; imem_rdata = 32'd0; pc_src = 2'b00;
      branch_taken = 1'b0; branch_target = 32'd0; jump_target = 32'd0; advance = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_pc", pc, 32'd0);
      chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
      chk("rst_inst", inst, 32'd0);
      chk("rst_opcode", {25'd0, opcode}, 32'd0);
      chk("rst_pc_plus4", pc_plus4, 32'd4);
      chk("rst_err", {31'd0, misaligned_err}, 32'd0);
      $display("reset held: req=%b pc=%h", imem_req, pc);

      rst_n = 1'b1;
      #1 chk("req_not_yet", {31'd0, imem_req}, 32'd0);
      @(negedge clk);
      chk("first_req", {31'd0, imem_req}, 32'd1);
      chk("first_addr", imem_addr, 32'd0);
      $display("reset released: req=%b addr=%h", imem_req, imem_addr);

      respond(32'h0050_0093, 2);
      chk("addi_opcode", {25'd0, opcode}, 32'h13);
      chk("addi_funct3", {29'd0, funct3}, 32'd0);
      chk("addi_funct7", {25'd0, funct7}, 32'd0);
      do_advance(2'b00, 1'b0, 32'd0, 32'd0, 32'h4);

      respond(32'h0000_0013, 0);
      do_advance(2'b00, 1'b1, 32'h40, 32'h80, 32'h8);

      respond(32'h0020_8663, 1);
      chk("beq_opcode", {25'd0, opcode}, 32'h63);
      do_advance(2'b01, 1'b1, 32'h20, 32'h0, 32'h20);
      respond(32'h0000_0013, 0);
      do_advance(2'b10, 1'b0, 32'h0, 32'h8, 32'h8);
      respond(32'h4020_86b3, 0);
      chk("sub_funct7", {25'd0, funct7}, 32'h20);
      do_advance(2'b01, 1'b0, 32'h20, 32'h0, 32'hC);
      respond(32'h0000_0013, 0);
      do_advance(2'b10, 1'b1, 32'h40, 32'h8, 32'h8);

      respond(32'h0F80_006F, 3);
      chk("jal_pc_plus4", pc_plus4, 32'hC);
      chk("jal_opcode", {25'd0, opcode}, 32'h6F);
      do_advance(2'b10, 1'b0, 32'h0, 32'h100, 32'h100);
      respond(32'h0000_0013, 0);
      do_advance(2'b11, 1'b1, 32'h500, 32'h600, 32'h104);
      respond(32'h0000_0013, 0);
      do_advance(2'b10, 1'b0, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
      respond(32'h0000_0013, 0);
      chk("wrap_pc_plus4", pc_plus4, 32'h0);
      do_advance(2'b00, 1'b0, 32'h0, 32'h0, 32'h0);

      // advance during FETCH, including the cycle valid arrives
      advance = 1'b1; pc_src = 2'b10; jump_target = 32'h300;
      @(negedge clk);
      chk("fetch_adv_req", {31'd0, imem_req}, 32'd1);
      chk("fetch_adv_pc", pc, 32'h0);
      imem_valid = 1'b1; imem_rdata = 32'h00A0_0113;
      exp_inst_q.push_back(32'h00A0_0113);
      @(negedge clk);
      begin
         logic [31:0] e;
         advance = 1'b0; imem_valid = 1'b0;
         pop_inst(e);
         chk("fetch_adv_inst", inst, e);
         chk("fetch_adv_valid", {31'd0, inst_valid}, 32'd1);
         chk("fetch_adv_req_low", {31'd0, imem_req}, 32'd0);
         chk("fetch_adv_pc2", pc, 32'h0);
         $display("advance+valid in FETCH: pc=%h inst=%h", pc, inst);
      end
      do_advance(2'b00, 1'b0, 32'h0, 32'h0, 32'h4);

      respond(32'h1020_0067, 0);
      pc_src = 2'b10; jump_target = 32'h102; advance = 1'b1;
      @(negedge clk);
      advance = 1'b0;
      chk("mis_err", {31'd0, misaligned_err}, 32'd1);
      chk("mis_req", {31'd0, imem_req}, 32'd0);
      chk("mis_pc", pc, 32'h4);
      chk("mis_inst_valid", {31'd0, inst_valid}, 32'd1);
      chk("mis_inst", inst, 32'h1020_0067);
      $display("misaligned jump 0x102: err=%b pc=%h", misaligned_err, pc);
      pc_src = 2'b00; jump_target = 32'h200;
      for (int i = 0; i < 3; i++) begin
         advance = 1'b1;
         @(negedge clk);
         advance = 1'b0;
         @(negedge clk);
      end
      chk("halt_req", {31'd0, imem_req}, 32'd0);
      chk("halt_pc", pc, 32'h4);
      chk("halt_err", {31'd0, misaligned_err}, 32'd1);
      $display("halt after advances: req=%b pc=%h", imem_req, pc);

      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("refetch_req", {31'd0, imem_req}, 32'd1);
      chk("refetch_err_clr", {31'd0, misaligned_err}, 32'd0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midfetch_req", {31'd0, imem_req}, 32'd0);
      chk("midfetch_pc", pc, 32'h0);
      chk("midfetch_inst_valid", {31'd0, inst_valid}, 32'd0);
      $display("reset mid-fetch: req=%b pc=%h", imem_req, pc);
      @(negedge clk);
      imem_valid = 1'b1; imem_rdata = 32'h1234_5678;
      @(negedge clk);
      imem_valid = 1'b0;
      chk("idle_valid_ignored", {31'd0, inst_valid}, 32'd0);
      chk("idle_inst", inst, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_addr", imem_addr, 32'd0);
      respond(32'h0000_0013, 0);
      $display("stray valid in IDLE: inst_valid stayed 0");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the single-cycle RV32I core. Holds the program counter, fetches one instruction word per cycle-group from instruction memory over a req/valid handshake, and presents the instruction plus its decoded `opcode`/`funct3`/`funct7` slices to the control unit. It also applies the control unit's `pc_src` decision, together with the branch outcome, to select the next PC.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset is asynchronous and active-low.
- `imem_req` out 1: fetch request to instruction memory.
- `imem_addr` out 32: fetch address; always equals `pc`.
- `imem_valid` in 1: memory response strobe for the outstanding request.
- `imem_rdata` in 32: instruction word; qualified by `imem_valid`.
- `pc_src` in 2: next-PC select from the control unit. Encodings: 00 = PC+4, 01 = branch, 10 = JAL/JALR, 11 = treated as 00.
- `branch_taken` in 1: branch condition result; used only when `pc_src`=01.
- `branch_target` in 32: PC+B-immediate.
- `jump_target` in 32: JAL/JALR target; the upstream logic has already cleared bit 0.
- `advance` in 1: the current instruction commits this cycle.
- `inst_valid` out 1: `inst` and the decoded slices are valid.
- `inst` out 32: latched instruction word.
- `opcode` out 7: `inst[6:0]`.
- `funct3` out 3: `inst[14:12]`.
- `funct7` out 7: `inst[31:25]`.
- `pc` out 32: address of `inst`.
- `pc_plus4` out 32: `pc`+4, the link value for JAL/JALR.
- `misaligned_err` out 1: sticky flag for a misaligned next-PC.

## Operation
FSM states:
- **IDLE** (reset state)
  - Goes to FETCH on the first clock after `rst_n` rises.
- **FETCH**
  - `imem_req`=1 and `imem_addr`=`pc`.
  - On `imem_valid`=1: latch `imem_rdata` into `inst`, set `inst_valid`, go to HOLD.
  - The memory may return `imem_valid` in the first request cycle (zero wait) or after any number of wait cycles.
- **HOLD**
  - `imem_req`=0 and `inst_valid`=1.
  - On `advance`=1, compute `next_pc`:
    - `pc_src`=00 or 11: `pc`+4.
    - `pc_src`=01: `branch_taken` ? `branch_target` : `pc`+4.
    - `pc_src`=10: `jump_target`.
  - If `next_pc[1:0]`==0: `pc`<=`next_pc`, `inst_valid`<=0, go to FETCH.
  - Otherwise: set `misaligned_err`, leave `pc` unchanged, go to HALT.
- **HALT**
  - Terminal state; only reset exits it.
  - `imem_req`=0. `inst_valid` stays 1 so the faulting instruction remains visible for debug.

Ignored inputs:
- `imem_valid` outside FETCH.
- `advance` outside HOLD.
- `advance` and `imem_valid` asserted in the same FETCH cycle: `advance` is ignored and `imem_valid` is honoured.

Arithmetic:
- All PC arithmetic is 32-bit modulo 2^32. `pc`=`32'hFFFF_FFFC` advances sequentially to `32'h0000_0000` with no flag.

## Timing
- Reset values: state IDLE, `pc`=`RESET_PC`, `inst`=0, `inst_valid`=0, `imem_req`=0, `misaligned_err`=0. Derived outputs follow: `opcode`/`funct3`/`funct7`=0, `pc_plus4`=`RESET_PC`+4.
- `imem_req` is registered. It first rises one cycle after `rst_n` deasserts.
- Fetch latency: `inst_valid` rises on the clock edge that samples `imem_valid`=1.
- Advance to the next request: `imem_req` is high in the cycle after `advance` is sampled.
- Peak rate with zero-wait memory: one instruction per 2 cycles.
- Reset mid-fetch: outputs return to their reset values immediately (asynchronous reset). Instruction memory shares `rst_n` and drops any outstanding response. A stray `imem_valid` while in IDLE is ignored.
- `imem_addr`, `imem_req`, `inst` and `pc` are stable for the whole of each request/hold interval.

## Structure
- Shared package `riscv_pkg` holds:
  - the `pc_src` encodings (`PC_SRC_SEQ`, `PC_SRC_BRANCH`, `PC_SRC_JUMP`);
  - the opcode localparams;
  - the fetch FSM state enum;
  - the default `RESET_PC`.
- One sub-module, `pc_next_sel`: combinational next-PC mux plus the `[1:0]` misalignment check. It is reused by the future pipelined variant.

## Test plan
- **Reset release:** hold `rst_n`=0 → `imem_req`=0, `pc`=0, `inst_valid`=0. Release `rst_n` → `imem_req`=1 with `imem_addr`=0 exactly one cycle later.
- **Sequential fetch:** `imem_rdata`=`32'h00500093` returned after 2 wait cycles → `inst_valid`=1, `opcode`=`7'b0010011`, `funct3`=0. Then `advance` with `pc_src`=00 → next request at `imem_addr`=4.
- **Branch:** `pc`=8, `pc_src`=01, `branch_target`=`32'h20`.
  - `branch_taken`=1 → next `imem_addr`=`32'h20`.
  - Repeat with `branch_taken`=0 → next `imem_addr`=`32'hC`.
- **JAL:** `pc`=8, `pc_src`=10, `jump_target`=`32'h100` → `pc_plus4`=`32'hC` while holding, then next `imem_addr`=`32'h100`.
- **Misaligned target:** `jump_target`=`32'h102` → `misaligned_err`=1, `imem_req` stays 0, `pc` unchanged. Further `advance` pulses have no effect until reset.
- **Reset mid-fetch:** assert `rst_n`=0 while FETCH waits → `imem_req` drops in the same cycle and `pc`=`RESET_PC`. An `imem_valid` pulse during IDLE → `inst_valid` stays 0.
